// File: rtl/bg_scroll_gen.sv
// rtl/bg_scroll_gen.sv - background scroll coordinate generator (optional BG_SCROLL_RASTER_EN: per-line shadow transfer)
module bg_scroll_gen #(
    parameter logic [8:0] H_OFFSET = 9'd0,
    parameter logic [7:0] V_OFFSET = 8'd0
) (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       pixel_ce,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       SCREEN_FLIP,
    input  logic       scroll_wr,
    input  logic [1:0] scroll_sel,
    input  logic [7:0] CPU_DIN,
    output logic [8:0] HPIXSCRL,
    output logic [7:0] VPIXSCRL,
    output logic       scroll_pending
);

    logic [8:0] shadow_x, shadow_x_nxt, active_x, h_cnt;
    logic [7:0] shadow_y, shadow_y_nxt, active_y, v_cnt;
    logic       hblank_q, vblank_q;
    logic       hb_rise, hb_fall, vb_rise, vb_fall;
    logic       wr_valid, xfer;

    assign hb_rise  = hblank & ~hblank_q;
    assign hb_fall  = ~hblank & hblank_q;
    assign vb_rise  = vblank & ~vblank_q;
    assign vb_fall  = ~vblank & vblank_q;
    assign wr_valid = scroll_wr && (scroll_sel != 2'd3);

`ifdef BG_SCROLL_RASTER_EN
    assign xfer = vb_rise | hb_rise;
`else
    assign xfer = vb_rise;
`endif

    // Shadow values including this cycle's CPU write, so a transfer in the same cycle picks it up
    always_comb begin
        shadow_x_nxt = shadow_x;
        shadow_y_nxt = shadow_y;
        if (scroll_wr) begin
            case (scroll_sel)
                2'd0:    shadow_x_nxt = {shadow_x[8], CPU_DIN};
                2'd1:    shadow_x_nxt = {CPU_DIN[0], shadow_x[7:0]};
                2'd2:    shadow_y_nxt = CPU_DIN;
                default: ;
            endcase
        end
    end

    // Blank edge detection flops
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            hblank_q <= hblank;
            vblank_q <= vblank;
        end
    end

    // Shadow registers, double-buffer transfer and pending flag
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            shadow_x       <= 9'd0;
            shadow_y       <= 8'd0;
            active_x       <= 9'd0;
            active_y       <= 8'd0;
            scroll_pending <= 1'b0;
        end else begin
            shadow_x <= shadow_x_nxt;
            shadow_y <= shadow_y_nxt;
            if (xfer) begin
                active_x       <= shadow_x_nxt;
                active_y       <= shadow_y_nxt;
                scroll_pending <= 1'b0;
            end else if (wr_valid) begin
                scroll_pending <= 1'b1;
            end
        end
    end

    // Horizontal counter: preload at line start, count visible pixels
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            h_cnt <= 9'd0;
        end else if (hb_fall) begin
            h_cnt <= active_x + H_OFFSET;
        end else if (pixel_ce && !hblank_q) begin
            h_cnt <= h_cnt + 9'd1;
        end
    end

    // Vertical counter: preload at frame start, count visible lines
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            v_cnt <= 8'd0;
        end else if (vb_fall) begin
            v_cnt <= active_y + V_OFFSET;
        end else if (hb_rise && !vblank_q) begin
            v_cnt <= v_cnt + 8'd1;
        end
    end

    // Output register with screen flip applied
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            HPIXSCRL <= 9'd0;
            VPIXSCRL <= 8'd0;
        end else begin
            HPIXSCRL <= h_cnt ^ {9{SCREEN_FLIP}};
            VPIXSCRL <= v_cnt ^ {8{SCREEN_FLIP}};
        end
    end

endmodule

// File: tb/tb_bg_scroll_gen.sv
// tb/tb_bg_scroll_gen.sv - scoreboard testbench for bg_scroll_gen
module tb_bg_scroll_gen;

    localparam logic [8:0] TB_H_OFF = 9'd0;
`ifdef BG_SCROLL_RASTER_EN
    localparam logic [7:0] TB_V_OFF = 8'd3;
`else
    localparam logic [7:0] TB_V_OFF = 8'd0;
`endif

    logic       master_clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_ce = 1'b0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic       SCREEN_FLIP = 1'b0;
    logic       scroll_wr = 1'b0;
    logic [1:0] scroll_sel = 2'd0;
    logic [7:0] CPU_DIN = 8'd0;
    logic [8:0] HPIXSCRL;
    logic [7:0] VPIXSCRL;
    logic       scroll_pending;

    bg_scroll_gen #(.H_OFFSET(TB_H_OFF), .V_OFFSET(TB_V_OFF)) dut (
        .master_clk    (master_clk),
        .reset         (reset),
        .pixel_ce      (pixel_ce),
        .hblank        (hblank),
        .vblank        (vblank),
        .SCREEN_FLIP   (SCREEN_FLIP),
        .scroll_wr     (scroll_wr),
        .scroll_sel    (scroll_sel),
        .CPU_DIN       (CPU_DIN),
        .HPIXSCRL      (HPIXSCRL),
        .VPIXSCRL      (VPIXSCRL),
        .scroll_pending(scroll_pending)
    );

    always #5 master_clk = ~master_clk;

    typedef struct {
        logic [8:0] h;
        logic [7:0] v;
        logic       p;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference state: scroll registers plus line/frame origin and elapsed pixels/lines
    int m_sx, m_sy, m_ax, m_ay, m_pend;
    int m_lx0, m_pix, m_ly0, m_lin;
    bit m_phb, m_pvb;

    function automatic void model_step();
        exp_t e;
        int h, v, oax, oay;
        bit hr, hf, vr, vf, xf;
        if (reset) begin
            m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0; m_pend = 0;
            m_lx0 = 0; m_pix = 0; m_ly0 = 0; m_lin = 0;
            m_phb = 0; m_pvb = 0;
            e.h = 9'd0; e.v = 8'd0; e.p = 1'b0;
            q.push_back(e);
            return;
        end
        h = (m_lx0 + m_pix) % 512;
        v = (m_ly0 + m_lin) % 256;
        if (SCREEN_FLIP) begin
            h = 511 - h;
            v = 255 - v;
        end
        e.h = 9'(h);
        e.v = 8'(v);
        hr = hblank && !m_phb;
        hf = !hblank && m_phb;
        vr = vblank && !m_pvb;
        vf = !vblank && m_pvb;
        oax = m_ax;
        oay = m_ay;
        if (scroll_wr) begin
            case (scroll_sel)
                2'd0: m_sx = (m_sx & 256) | int'(CPU_DIN);
                2'd1: m_sx = (m_sx & 255) | (CPU_DIN[0] ? 256 : 0);
                2'd2: m_sy = int'(CPU_DIN);
                default: ;
            endcase
            if (scroll_sel != 2'd3) m_pend = 1;
        end
        xf = vr;
`ifdef BG_SCROLL_RASTER_EN
        xf = xf | hr;
`endif
        if (xf) begin
            m_ax = m_sx;
            m_ay = m_sy;
            m_pend = 0;
        end
        if (hf) begin
            m_lx0 = (oax + int'(TB_H_OFF)) % 512;
            m_pix = 0;
        end else if (pixel_ce && !m_phb) begin
            m_pix = m_pix + 1;
        end
        if (vf) begin
            m_ly0 = (oay + int'(TB_V_OFF)) % 256;
            m_lin = 0;
        end else if (hr && !m_pvb) begin
            m_lin = m_lin + 1;
        end
        m_phb = hblank;
        m_pvb = vblank;
        e.p = m_pend[0];
        q.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents registered outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge master_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (HPIXSCRL !== e.h || VPIXSCRL !== e.v || scroll_pending !== e.p) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t got H=%03h V=%02h P=%0b expected H=%03h V=%02h P=%0b",
                             $time, HPIXSCRL, VPIXSCRL, scroll_pending, e.h, e.v, e.p);
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge master_clk);
        @(negedge master_clk);
        scroll_wr = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        scroll_wr  = 1'b1;
        scroll_sel = s;
        CPU_DIN    = d;
        tick();
    endtask

    task automatic line(input int act, input int blk, input int wr_pct);
        hblank = 1'b0;
        for (int i = 0; i < act; i++) begin
            pixel_ce = ($urandom_range(0, 3) != 0);
            if (int'($urandom_range(0, 99)) < wr_pct) begin
                scroll_wr  = 1'b1;
                scroll_sel = 2'($urandom_range(0, 3));
                CPU_DIN    = 8'($urandom);
            end
            tick();
        end
        hblank = 1'b1;
        for (int i = 0; i < blk; i++) begin
            pixel_ce = ~pixel_ce;
            tick();
        end
    endtask

    task automatic frame(input int lines, input int vlines, input int act, input int wr_pct, input bit bypass);
        vblank = 1'b0;
        for (int l = 0; l < lines; l++) line(act, 4, wr_pct);
        vblank = 1'b1;
        if (bypass) begin
            scroll_wr  = 1'b1;
            scroll_sel = 2'd0;
            CPU_DIN    = 8'h55;
            line(0, 3, 0);
        end
        for (int l = 0; l < vlines; l++) line(act, 4, 0);
    endtask

    initial begin
        @(negedge master_clk);
        // Reset held with pixel_ce toggling
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pixel_ce = ~pixel_ce;
            tick();
        end
        reset = 1'b0;
        pixel_ce = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Scroll X=0x1F0, Y=0x20 then frames wide enough to wrap H
        wr(2'd0, 8'hF0);
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h20);
        hblank = 1'b1;
        frame(0, 1, 8, 0, 1'b0);
        frame(3, 1, 24, 0, 1'b0);

        // Mid-frame Y write, then a frame to observe it
        vblank = 1'b0;
        line(10, 4, 0);
        wr(2'd2, 8'h80);
        line(10, 4, 0);
        frame(2, 1, 10, 0, 1'b0);
        frame(2, 1, 10, 0, 1'b0);

        // Write coinciding with vblank rise
        frame(2, 1, 10, 0, 1'b1);
        frame(2, 1, 10, 0, 1'b0);

        // Screen flip
        SCREEN_FLIP = 1'b1;
        frame(3, 1, 12, 0, 1'b0);
        SCREEN_FLIP = 1'b0;

        // Per-line X write and Y near wrap
        wr(2'd2, 8'hFE);
        vblank = 1'b0;
        for (int l = 0; l < 5; l++) line(10, 4, 0);
        wr(2'd0, 8'h08);
        wr(2'd1, 8'h00);
        line(10, 4, 0);
        line(10, 4, 0);
        frame(2, 1, 10, 0, 1'b0);
        frame(2, 1, 10, 0, 1'b0);

        // Randomized frames with occasional mid-line reset
        for (int f = 0; f < 30; f++) begin
            SCREEN_FLIP = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                hblank = 1'b0;
                reset  = 1'b1;
                tick();
                reset  = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    pixel_ce = $urandom_range(0, 1) == 1;
                    tick();
                end
            end
            frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 2)),
                  int'($urandom_range(3, 40)), 10, ($urandom_range(0, 3) == 0));
        end

        tick();
        tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
